// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// data_mem_arbiter: round-robin two-port arbiter/sequencer for the data RAM (IDLE->ACCESS->RESP).
// Rev 1.0. Optional address range check enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req_i,
    input  logic                     m0_we_i,
    input  logic [1:0]               m0_dtype_i,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_wdata_i,
    output logic                     m0_gnt_o,
    output logic                     m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m0_rdata_o,
    output logic                     m0_err_o,
    input  logic                     m1_req_i,
    input  logic                     m1_we_i,
    input  logic [1:0]               m1_dtype_i,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_wdata_i,
    output logic                     m1_gnt_o,
    output logic                     m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m1_rdata_o,
    output logic                     m1_err_o,
    output logic                     ram_we_o,
    output logic [1:0]               ram_dtype_o,
    output logic [ADDRESS_WIDTH-1:0] ram_a_o,
    output logic [DATA_WIDTH-1:0]    ram_wd_o,
    input  logic [DATA_WIDTH-1:0]    ram_rd_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    logic [1:0]               state_q, state_d;
    logic                     last_q;
    logic                     port_q;
    logic                     we_q;
    logic [1:0]               dtype_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;

    logic w_gnt0, w_gnt1, w_legal, w_aligned, w_in_range;

    // Tie goes to the port that was not granted last; no grant while in reset.
    assign w_gnt0 = !rst && (state_q == S_IDLE) && m0_req_i && (!m1_req_i || last_q);
    assign w_gnt1 = !rst && (state_q == S_IDLE) && m1_req_i && (!m0_req_i || !last_q);

    always_comb begin
        w_aligned = 1'b0;
        case (dtype_q)
            DT_WORD: w_aligned = (addr_q[1:0] == 2'b00);
            DT_HALF: w_aligned = !addr_q[0];
            DT_BYTE: w_aligned = 1'b1;
            default: w_aligned = 1'b0;
        endcase
    end

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [ADDRESS_WIDTH:0] RANGE_LO = (ADDRESS_WIDTH+1)'(32'h0000_0100);
    localparam logic [ADDRESS_WIDTH:0] RANGE_HI = (ADDRESS_WIDTH+1)'(32'h0001_FFFF);

    logic [ADDRESS_WIDTH:0] w_size_m1;
    logic [ADDRESS_WIDTH:0] w_end;

    always_comb begin
        w_size_m1 = '0;
        case (dtype_q)
            DT_WORD: w_size_m1 = (ADDRESS_WIDTH+1)'(3);
            DT_HALF: w_size_m1 = (ADDRESS_WIDTH+1)'(1);
            default: w_size_m1 = '0;
        endcase
    end

    // One extra bit so the last-byte address cannot wrap past the top of the space.
    assign w_end      = {1'b0, addr_q} + w_size_m1;
    assign w_in_range = ({1'b0, addr_q} >= RANGE_LO) && (w_end <= RANGE_HI);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_legal = w_aligned && w_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (m0_req_i || m1_req_i) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m0_gnt_o    = w_gnt0;
        m1_gnt_o    = w_gnt1;
        ram_we_o    = !rst && (state_q == S_ACCESS) && we_q && w_legal;
        m0_rvalid_o = (state_q == S_RESP) && !port_q;
        m1_rvalid_o = (state_q == S_RESP) && port_q;
        m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
        m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
        m0_err_o    = m0_rvalid_o && err_q;
        m1_err_o    = m1_rvalid_o && err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            dtype_q <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                last_q  <= w_gnt1;
                port_q  <= w_gnt1;
                we_q    <= w_gnt1 ? m1_we_i    : m0_we_i;
                dtype_q <= w_gnt1 ? m1_dtype_i : m0_dtype_i;
                addr_q  <= w_gnt1 ? m1_addr_i  : m0_addr_i;
                wdata_q <= w_gnt1 ? m1_wdata_i : m0_wdata_i;
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= (w_legal && !we_q) ? ram_rd_i : '0;
                err_q   <= !w_legal;
            end
        end
    end

    // RAM address/type/data follow the capture registers, so they hold outside ACCESS.
    assign ram_a_o     = addr_q;
    assign ram_dtype_o = dtype_q;
    assign ram_wd_o    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_data_mem_arbiter: directed scoreboard bench for data_mem_arbiter with a byte-addressed RAM model.
// Rev 1.0. Expectations follow DMEM_RANGE_CHECK_EN when defined.
module tb_data_mem_arbiter;

    localparam logic [1:0] W = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] H = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_dtype, m1_dtype;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [1:0]  ram_dtype;
    logic [31:0] ram_a, ram_wd, ram_rd;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_dtype_i(m0_dtype), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_dtype_i(m1_dtype), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .ram_we_o(ram_we), .ram_dtype_o(ram_dtype), .ram_a_o(ram_a), .ram_wd_o(ram_wd),
        .ram_rd_i(ram_rd)
    );

    // Little-endian byte RAM, combinational read, zero-extended sub-word reads
    logic [7:0] mem [0:131071];
    initial for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a[16:0]] <= ram_wd[7:0];
            if (ram_dtype != B) mem[ram_a[16:0] + 17'd1] <= ram_wd[15:8];
            if (ram_dtype == W) begin
                mem[ram_a[16:0] + 17'd2] <= ram_wd[23:16];
                mem[ram_a[16:0] + 17'd3] <= ram_wd[31:24];
            end
        end
    end

    always_comb begin
        ram_rd = {24'h0, mem[ram_a[16:0]]};
        if (ram_dtype == H) ram_rd = {16'h0, mem[ram_a[16:0] + 17'd1], mem[ram_a[16:0]]};
        if (ram_dtype == W) ram_rd = {mem[ram_a[16:0] + 17'd3], mem[ram_a[16:0] + 17'd2],
                                      mem[ram_a[16:0] + 17'd1], mem[ram_a[16:0]]};
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          we_cnt = 0;
    logic [31:0] last_we_a = 32'h0;
    logic [31:0] last_we_d = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_resp(input int p, input logic err, input logic [31:0] rd);
        exp_t e;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid port%0d: got rvalid at cycle %0d expected none", p, cyc);
        end else begin
            e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("p%0d_err", p), {31'h0, err}, {31'h0, e.err});
            chk($sformatf("p%0d_rdata", p), rd, e.rdata);
            chk($sformatf("p%0d_latency_cycle", p), cyc, e.cyc);
        end
    endtask

    // Response monitor, decoupled from stimulus
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid && m1_rvalid) chk("both_rvalid", 32'h1, 32'h0);
            if (m0_rvalid) pop_resp(0, m0_err, m0_rdata);
            if (m1_rvalid) pop_resp(1, m1_err, m1_rdata);
        end
        if (ram_we) begin
            we_cnt++;
            last_we_a = ram_a;
            last_we_d = ram_wd;
        end
    end

    task automatic issue(input int p, input logic we, input logic [1:0] dt,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic eerr, input logic [31:0] erd,
                         input bit want_resp, output int gcyc);
        bit   got = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        if (p == 0) begin
            m0_req = 1'b1; m0_we = we; m0_dtype = dt; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_dtype = dt; m1_addr = a; m1_wdata = wd;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((p == 0) ? m0_gnt : m1_gnt) got = 1'b1;
        end
        gcyc = cyc;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL gnt_timeout port%0d: got no gnt expected gnt within 20 cycles", p);
        end else if (want_resp) begin
            e.err = eerr; e.rdata = erd; e.cyc = cyc + 2;
            if (p == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(posedge clk); #1;
        if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0a, g0b, g1a, g1b, g, w0;
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_dtype = W; m0_addr = 32'h10000; m0_wdata = 32'h1;
        m1_req = 1'b0; m1_we = 1'b0; m1_dtype = W; m1_addr = 32'h0; m1_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_gnt0", {31'h0, m0_gnt}, 32'h0);
        chk("reset_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("reset_ram_we", {31'h0, ram_we}, 32'h0);
        chk("reset_ram_a", ram_a, 32'h0);
        chk("reset_ram_wd", ram_wd, 32'h0);
        chk("reset_ram_dtype", {30'h0, ram_dtype}, 32'h0);
        chk("reset_rdata_err", m0_rdata | m1_rdata | {30'h0, m1_err, m0_err}, 32'h0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        rst = 1'b0;

        // Both ports requesting continuously: 0,1,0,1 three cycles apart
        fork
            begin
                issue(0, 1'b1, W, 32'h10100, 32'h11111111, 1'b0, 32'h0, 1'b1, g0a);
                issue(0, 1'b0, W, 32'h10200, 32'h0, 1'b0, 32'h22222222, 1'b1, g0b);
            end
            begin
                issue(1, 1'b1, W, 32'h10200, 32'h22222222, 1'b0, 32'h0, 1'b1, g1a);
                issue(1, 1'b0, W, 32'h10100, 32'h0, 1'b0, 32'h11111111, 1'b1, g1b);
            end
        join
        chk("rr_gap_0_1", g1a - g0a, 32'd3);
        chk("rr_gap_1_0", g0b - g1a, 32'd3);
        chk("rr_gap_0_1b", g1b - g0b, 32'd3);
        repeat (3) @(posedge clk);

        w0 = we_cnt;
        issue(0, 1'b1, W, 32'h10000, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, g);
        repeat (3) @(negedge clk);
        chk("word_write_we_count", we_cnt - w0, 32'd1);
        chk("word_write_addr", last_we_a, 32'h10000);
        chk("word_write_data", last_we_d, 32'hDEADBEEF);
        issue(0, 1'b0, W, 32'h10000, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, g);
        issue(1, 1'b0, B, 32'h10003, 32'h0, 1'b0, 32'h000000DE, 1'b1, g);
        issue(1, 1'b0, H, 32'h10002, 32'h0, 1'b0, 32'h0000DEAD, 1'b1, g);

        // Illegal accesses: no RAM write, err=1, rdata=0
        w0 = we_cnt;
        issue(0, 1'b0, W, 32'h10002, 32'h0, 1'b1, 32'h0, 1'b1, g);
        issue(1, 1'b1, H, 32'h10001, 32'h0000FFFF, 1'b1, 32'h0, 1'b1, g);
        issue(0, 1'b1, 2'b11, 32'h10000, 32'h55, 1'b1, 32'h0, 1'b1, g);
        repeat (3) @(negedge clk);
        chk("illegal_no_we", we_cnt - w0, 32'd0);

        // Reset during the ACCESS cycle of a write drops it
        issue(0, 1'b1, W, 32'h10010, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, g);
        issue(0, 1'b1, W, 32'h10010, 32'h12345678, 1'b0, 32'h0, 1'b0, g);
        w0 = we_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_access_ram_we", {31'h0, ram_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_access_no_write", we_cnt - w0, 32'd0);
        issue(0, 1'b0, W, 32'h10010, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, g);

        // Range boundaries
`ifdef DMEM_RANGE_CHECK_EN
        issue(0, 1'b0, W, 32'h80, 32'h0, 1'b1, 32'h0, 1'b1, g);
`else
        issue(0, 1'b0, W, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1, g);
`endif
        issue(1, 1'b1, W, 32'h1FFFE, 32'hAAAA5555, 1'b1, 32'h0, 1'b1, g);
        issue(1, 1'b1, B, 32'h1FFFF, 32'h0000007A, 1'b0, 32'h0, 1'b1, g);
        issue(0, 1'b0, B, 32'h1FFFF, 32'h0, 1'b0, 32'h0000007A, 1'b1, g);

        repeat (5) @(negedge clk);
        chk("sb0_drained", sb0.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data RAM. It lets the load/store path (port 0) and a secondary master such as a loader or debug port (port 1) share the single RAM port. Arbitration is round-robin. Each granted access is captured, checked for alignment and legality, driven onto the RAM for exactly one cycle, and answered with a one-cycle response pulse. The block sits between the requesters and the RAM's WE/dataType/A/WD/RD pins.

## Interface
- ADDRESS_WIDTH, 32, byte address width on both ports and the RAM side
- DATA_WIDTH, 32, data width on both ports and the RAM side
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  request from port N (N = 0, 1)
- mN_we  in  1  1 = write, 0 = read
- mN_dtype  in  2  00 word, 01 byte, 10 halfword, 11 illegal
- mN_addr  in  ADDRESS_WIDTH  byte address
- mN_wdata  in  DATA_WIDTH  write data, LSB-aligned
- mN_gnt  out  1  one-cycle pulse; request fields are captured on this edge
- mN_rvalid  out  1  one-cycle response pulse
- mN_rdata  out  DATA_WIDTH  read data, valid with rvalid; 0 for writes and errors
- mN_err  out  1  valid with rvalid; access was rejected
- ram_we  out  1  RAM write enable
- ram_dtype  out  2  RAM access type
- ram_a  out  ADDRESS_WIDTH  RAM address
- ram_wd  out  DATA_WIDTH  RAM write data
- ram_rd  in  DATA_WIDTH  RAM combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- IDLE:
  - If any mN_req is high, mN_gnt is asserted combinationally for the winner.
  - addr, we, dtype, wdata and the port id are registered on that edge.
  - Next state is ACCESS. Without requests, the FSM stays in IDLE.
- Arbitration:
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - After reset, the last-granted pointer is 1, so port 0 wins the first tie.
- Legality check, performed on the captured fields in ACCESS:
  - dtype 11 is illegal.
  - A word needs addr[1:0] == 0.
  - A halfword needs addr[0] == 0.
- ACCESS:
  - ram_a, ram_dtype and ram_wd are driven from the capture registers.
  - ram_we = captured we AND legal.
  - For a legal read, ram_rd is registered into the response data register.
  - Next state is RESP.
- RESP:
  - Only the captured port sees rvalid=1, with rdata and err.
  - The other port's rvalid stays 0.
  - Next state is IDLE.
- Illegal access: no RAM write, err=1, rdata=0.
- Requester rules:
  - Hold req and all fields stable until gnt.
  - Dropping req before gnt withdraws the request without side effects.
  - req still high after gnt counts as a new request.
  - A requester may issue the next request while waiting for rvalid; it is granted in the next IDLE.
- In IDLE and RESP, the RAM outputs are ram_we=0, and ram_a, ram_dtype and ram_wd hold their last values.

## Timing
- Request seen in IDLE at cycle T: gnt at T, RAM access at T+1, rvalid at T+2.
- Throughput: one access per 3 cycles. Back-to-back alternating ports give gnts at T, T+3, T+6, …
- Read latency from gnt to rvalid: 2 cycles.
- A write commits to RAM on the rising edge that ends cycle T+1.
- Reset values:
  - All gnt, rvalid, err and ram_we are 0.
  - All rdata, ram_a, ram_wd and ram_dtype are 0.
  - FSM is IDLE; last-granted pointer is 1.
- Reset mid-operation:
  - rst high during ACCESS forces ram_we=0 in that cycle, so the write is dropped.
  - No rvalid is issued for the aborted access.
  - gnt is suppressed in any cycle with rst=1.

## Configuration
- DMEM_RANGE_CHECK_EN defined:
  - An access is also illegal if addr < 0x100, or if addr + size − 1 > 0x1FFFF (size = 4, 2 or 1).
  - Such an access returns err=1 with no RAM write.
- Undefined: the range check is removed. Only alignment and dtype legality are checked.

## Test plan
- Port 0 writes word 0xDEADBEEF to 0x10000, then reads it back -> write: ram_we=1 in exactly one cycle with ram_a=0x10000; read: rvalid two cycles after gnt with rdata=0xDEADBEEF, err=0.
- Both ports request continuously from reset -> grant order 0, 1, 0, 1, with gnts 3 cycles apart and each rvalid routed only to its own port.
- Port 1 reads byte at 0x10003 after the word write above -> rdata=0x000000DE; a halfword read at 0x10002 -> 0x0000DEAD.
- Misaligned accesses: word at 0x10002, halfword at 0x10001, and dtype 11 -> each gives err=1, rdata=0, and ram_we never asserts.
- rst asserted in the ACCESS cycle of a write of 0x12345678 to 0x10010 -> no ram_we pulse, no rvalid, and a later read of 0x10010 returns the old contents.
- With DMEM_RANGE_CHECK_EN, a word write at 0x1FFFE and a read at 0x80 -> err=1 for both; without the macro, the 0x80 read returns err=0.
